// File: rtl/drum_pkg.sv
// Shared sizes, state encoding and map helpers for the drum step sequencer.
// Pure declarations: no logic, no latency, no flow control.
package drum_pkg;
  localparam int STEPS  = 32;
  localparam int STEP_W = $clog2(STEPS);
  localparam int CODE_W = 3;
  localparam int MAP_W  = STEPS * CODE_W;
  localparam int DUR_W  = 10;

  localparam logic [CODE_W-1:0] CODE_REST = '0;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } seq_state_t;

  function automatic logic [CODE_W-1:0] step_code(input logic [MAP_W-1:0] map,
                                                  input logic [STEP_W-1:0] idx);
    return map[CODE_W*idx +: CODE_W];
  endfunction
endpackage

// File: rtl/step_sequencer_if.sv
// Control-side inputs and voice-side outputs of the step sequencer.
// Outputs are registered in the sequencer; no backpressure, the voice stage must accept every trigger.
interface step_sequencer_if;
  import drum_pkg::*;

  logic                 run;
  logic                 tick_ms;
  logic [DUR_W-1:0]     eight_note;
  logic [MAP_W-1:0]     map_in;
  logic                 map_load;
  logic [CODE_W-1:0]    cur_sample;
  logic                 sample_valid;
  logic [STEP_W-1:0]    step_idx;
  logic                 bar_start;
  logic                 map_pending;

  modport master (
    output run, tick_ms, eight_note, map_in, map_load,
    input  cur_sample, sample_valid, step_idx, bar_start, map_pending
  );

  modport slave (
    input  run, tick_ms, eight_note, map_in, map_load,
    output cur_sample, sample_valid, step_idx, bar_start, map_pending
  );
endinterface

// File: rtl/step_timer.sv
// Counts ms ticks within one step against a duration frozen at step start.
// o_step_done is combinational on the boundary tick; no backpressure.
module step_timer
  import drum_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_tick,
  input  logic [DUR_W-1:0] i_eight_note,
  output logic             o_step_done
);
  logic [DUR_W-1:0] r_ms_cnt;
  logic [DUR_W-1:0] r_dur_q;
  logic [DUR_W-1:0] w_cnt_inc;

  assign w_cnt_inc   = r_ms_cnt + DUR_W'(1);
  assign o_step_done = i_tick && (w_cnt_inc == r_dur_q);

  // A zero duration would never match, so it is clamped to one tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ms_cnt <= '0;
      r_dur_q  <= '0;
    end else if (i_start) begin
      r_ms_cnt <= '0;
      r_dur_q  <= (i_eight_note == '0) ? DUR_W'(1) : i_eight_note;
    end else if (i_tick) begin
      r_ms_cnt <= w_cnt_inc;
    end
  end
endmodule

// File: rtl/step_sequencer.sv
// Plays a double-buffered 32-step pattern; step outputs update 1 clk after the boundary tick.
// No backpressure: triggers are one-clk pulses, map loads in PLAY are deferred to the bar boundary.
module step_sequencer
  import drum_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  step_sequencer_if.slave    bus
);
  seq_state_t          r_state, w_state_nxt;
  logic [MAP_W-1:0]    r_active, r_shadow, w_active_nxt;
  logic                r_pending;
  logic [STEP_W-1:0]   r_step_idx, w_idx_nxt;
  logic [CODE_W-1:0]   r_cur_sample, w_code_nxt;
  logic                r_sample_valid, r_bar_start;
  logic                w_tick, w_step_done, w_start, w_stop, w_last_step, w_bar_edge;

  step_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_start),
    .i_tick       (w_tick),
    .i_eight_note (bus.eight_note),
    .o_step_done  (w_step_done)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.run)  w_state_nxt = PLAY;
      PLAY: if (!bus.run) w_state_nxt = IDLE;
    endcase
  end

  assign w_tick      = (r_state == PLAY) && bus.tick_ms;
  assign w_last_step = (r_step_idx == STEP_W'(STEPS - 1));

  always_comb begin
    w_start   = 1'b0;
    w_stop    = 1'b0;
    w_idx_nxt = '0;
    case (r_state)
      IDLE: w_start = bus.run;
      PLAY: begin
        w_stop    = !bus.run;
        w_start   = bus.run && w_step_done;
        w_idx_nxt = w_last_step ? '0 : r_step_idx + STEP_W'(1);
      end
    endcase
  end

  // Stopping counts as a bar boundary too, so a pending map is never stranded.
  assign w_bar_edge = (r_state == PLAY) && (w_stop || (w_start && w_last_step));

  always_comb begin
    w_active_nxt = r_active;
    if (r_state == IDLE) begin
      if (bus.map_load) w_active_nxt = bus.map_in;
    end else if (w_bar_edge) begin
      if (bus.map_load)   w_active_nxt = bus.map_in;
      else if (r_pending) w_active_nxt = r_shadow;
    end
  end

  assign w_code_nxt = step_code(w_active_nxt, w_idx_nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else begin
      r_active <= w_active_nxt;
      if (r_state == PLAY) begin
        if (w_bar_edge) begin
          r_pending <= 1'b0;
        end else if (bus.map_load) begin
          r_shadow  <= bus.map_in;
          r_pending <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_idx     <= '0;
      r_cur_sample   <= CODE_REST;
      r_sample_valid <= 1'b0;
      r_bar_start    <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_bar_start    <= 1'b0;
      if (w_stop) begin
        r_step_idx   <= '0;
        r_cur_sample <= CODE_REST;
      end else if (w_start) begin
        r_step_idx     <= w_idx_nxt;
        r_cur_sample   <= w_code_nxt;
        r_sample_valid <= (w_code_nxt != CODE_REST);
        r_bar_start    <= (w_idx_nxt == '0);
      end
    end
  end

  assign bus.step_idx     = r_step_idx;
  assign bus.cur_sample   = r_cur_sample;
  assign bus.sample_valid = r_sample_valid;
  assign bus.bar_start    = r_bar_start;
  assign bus.map_pending  = r_pending;
endmodule
